// File: rtl/inj_error_monitor.sv
// inj_error_monitor: classifies DUT/golden output mismatch bursts as transient or permanent and keeps saturating statistics (optional INJ_MON_PER_OUTPUT_EN adds per-output mismatch counters)
module inj_error_monitor #(
  parameter int CNT_W       = 16,
  parameter int PERM_THRESH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             y1,
  input  logic             y2,
  input  logic             y1_ref,
  input  logic             y2_ref,
  output logic             err_now,
  output logic             perm_fault,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
`ifdef INJ_MON_PER_OUTPUT_EN
  output logic [CNT_W-1:0] y1_mism_cnt,
  output logic [CNT_W-1:0] y2_mism_cnt,
`endif
  output logic             first_valid
);
  typedef enum logic [1:0] {IDLE = 2'd0, WATCH = 2'd1, ERROR = 2'd2, PERM = 2'd3} state_e;
  state_e state_q, state_d;
  logic err_q, err_d, perm_q, perm_d, fv_q, fv_d;
  logic [CNT_W-1:0] run_q, run_d, cyc_q, cyc_d, mism_q, mism_d;
  logic [CNT_W-1:0] evt_q, evt_d, trans_q, trans_d, first_q, first_d;
  logic [CNT_W-1:0] m1_q, m1_d, m2_q, m2_d;
  logic [CNT_W:0] run_nx;
  logic mis1, mis2, mis;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
  assign mis1   = y1 ^ y1_ref;
  assign mis2   = y2 ^ y2_ref;
  assign mis    = mis1 | mis2;
  assign run_nx = {1'b0, run_q} + (CNT_W+1)'(1);
  // next state and statistics: clr beats en beats the FSM; sampling only outside IDLE
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    perm_d  = perm_q;
    fv_d    = fv_q;
    run_d   = run_q;
    cyc_d   = cyc_q;
    mism_d  = mism_q;
    evt_d   = evt_q;
    trans_d = trans_q;
    first_d = first_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    if (clr) begin
      state_d = IDLE;
      err_d   = 1'b0;
      perm_d  = 1'b0;
      fv_d    = 1'b0;
      run_d   = '0;
      cyc_d   = '0;
      mism_d  = '0;
      evt_d   = '0;
      trans_d = '0;
      first_d = '0;
      m1_d    = '0;
      m2_d    = '0;
    end else if (!en) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = WATCH;
    end else begin
      err_d  = mis;
      cyc_d  = sat(cyc_q);
      mism_d = mis ? sat(mism_q) : mism_q;
      m1_d   = mis1 ? sat(m1_q) : m1_q;
      m2_d   = mis2 ? sat(m2_q) : m2_q;
      if (state_q == WATCH && mis) begin
        state_d = ERROR;
        run_d   = CNT_W'(1);
        evt_d   = sat(evt_q);
        first_d = fv_q ? first_q : cyc_q;
        fv_d    = 1'b1;
      end else if (state_q == ERROR && mis) begin
        run_d = run_nx[CNT_W-1:0];
        if (run_nx == (CNT_W+1)'(PERM_THRESH)) begin
          state_d = PERM;
          perm_d  = 1'b1;
        end
      end else if (state_q == ERROR) begin
        state_d = WATCH;
        trans_d = sat(trans_q);
      end
    end
  end
  // state register with asynchronous reset that also discards any burst in progress
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      perm_q  <= 1'b0;
      fv_q    <= 1'b0;
      run_q   <= '0;
      cyc_q   <= '0;
      mism_q  <= '0;
      evt_q   <= '0;
      trans_q <= '0;
      first_q <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      perm_q  <= perm_d;
      fv_q    <= fv_d;
      run_q   <= run_d;
      cyc_q   <= cyc_d;
      mism_q  <= mism_d;
      evt_q   <= evt_d;
      trans_q <= trans_d;
      first_q <= first_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
    end
  end
  assign err_now       = err_q;
  assign perm_fault    = perm_q;
  assign state_o       = state_q;
  assign mism_cnt      = mism_q;
  assign event_cnt     = evt_q;
  assign trans_cnt     = trans_q;
  assign first_err_cyc = first_q;
  assign first_valid   = fv_q;
`ifdef INJ_MON_PER_OUTPUT_EN
  assign y1_mism_cnt = m1_q;
  assign y2_mism_cnt = m2_q;
`else
  logic unused_ok;
  assign unused_ok = ^{m1_q, m2_q};
`endif
endmodule

// File: tb/tb_inj_error_monitor.sv
// tb_inj_error_monitor: random and directed stimulus against a burst-level reference model, on a 16-bit and a 4-bit instance
module tb_inj_error_monitor;
  localparam int TH = 4;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, clr = 1'b0;
  logic y1 = 1'b0, y2 = 1'b0, y1_ref = 1'b0, y2_ref = 1'b0;
  logic a_err, a_perm, a_fv, b_err, b_perm, b_fv;
  logic [1:0] a_st, b_st;
  logic [15:0] a_mism, a_evt, a_trans, a_first;
  logic [3:0] b_mism, b_evt, b_trans, b_first;
`ifdef INJ_MON_PER_OUTPUT_EN
  logic [15:0] a_y1c, a_y2c;
  logic [3:0] b_y1c, b_y2c;
`endif
  int checks = 0, failures = 0;
  int maxv[2] = '{65535, 15};
  int m_err[2], m_perm[2], m_fv[2], m_mism[2], m_evt[2], m_trans[2], m_first[2];
  int m_cyc[2], m_blen[2], m_act[2], m_inperm[2], m_y1c[2], m_y2c[2];
  bit burst = 1'b0;
  bit r1, r2;

  always #20 clk = ~clk;

  inj_error_monitor #(.CNT_W(16), .PERM_THRESH(TH)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .y1(y1), .y2(y2), .y1_ref(y1_ref), .y2_ref(y2_ref),
    .err_now(a_err), .perm_fault(a_perm), .state_o(a_st), .mism_cnt(a_mism), .event_cnt(a_evt),
    .trans_cnt(a_trans), .first_err_cyc(a_first),
`ifdef INJ_MON_PER_OUTPUT_EN
    .y1_mism_cnt(a_y1c), .y2_mism_cnt(a_y2c),
`endif
    .first_valid(a_fv));

  inj_error_monitor #(.CNT_W(4), .PERM_THRESH(TH)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .y1(y1), .y2(y2), .y1_ref(y1_ref), .y2_ref(y2_ref),
    .err_now(b_err), .perm_fault(b_perm), .state_o(b_st), .mism_cnt(b_mism), .event_cnt(b_evt),
    .trans_cnt(b_trans), .first_err_cyc(b_first),
`ifdef INJ_MON_PER_OUTPUT_EN
    .y1_mism_cnt(b_y1c), .y2_mism_cnt(b_y2c),
`endif
    .first_valid(b_fv));

  function automatic int sat(int v, int mx);
    return v >= mx ? mx : v + 1;
  endfunction

  function automatic int mstate(int i);
    return !m_act[i] ? 0 : m_inperm[i] ? 3 : m_blen[i] > 0 ? 2 : 1;
  endfunction

  task automatic model_clear(int i, bit full);
    m_act[i] = 0; m_blen[i] = 0; m_inperm[i] = 0; m_err[i] = 0;
    if (full) begin
      m_perm[i] = 0; m_fv[i] = 0; m_mism[i] = 0; m_evt[i] = 0; m_trans[i] = 0;
      m_first[i] = 0; m_cyc[i] = 0; m_y1c[i] = 0; m_y2c[i] = 0;
    end
  endtask

  task automatic model_step();
    bit m1, m2, mis;
    m1 = y1 ^ y1_ref;
    m2 = y2 ^ y2_ref;
    mis = m1 | m2;
    for (int i = 0; i < 2; i++) begin
      if (clr) model_clear(i, 1'b1);
      else if (!en) model_clear(i, 1'b0);
      else if (!m_act[i]) m_act[i] = 1;
      else begin
        m_err[i] = mis;
        if (mis) m_mism[i] = sat(m_mism[i], maxv[i]);
        if (m1) m_y1c[i] = sat(m_y1c[i], maxv[i]);
        if (m2) m_y2c[i] = sat(m_y2c[i], maxv[i]);
        if (!m_inperm[i]) begin
          if (mis) begin
            if (m_blen[i] == 0) begin
              m_evt[i] = sat(m_evt[i], maxv[i]);
              if (!m_fv[i]) begin m_first[i] = m_cyc[i]; m_fv[i] = 1; end
            end
            m_blen[i]++;
            if (m_blen[i] == TH) begin m_inperm[i] = 1; m_perm[i] = 1; end
          end else if (m_blen[i] > 0) begin
            m_trans[i] = sat(m_trans[i], maxv[i]);
            m_blen[i] = 0;
          end
        end
        m_cyc[i] = sat(m_cyc[i], maxv[i]);
      end
    end
  endtask

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit e, bit c, bit m1, bit m2);
    @(negedge clk);
    en = e; clr = c;
    y1_ref = 1'($urandom); y2_ref = 1'($urandom);
    y1 = y1_ref ^ m1; y2 = y2_ref ^ m2;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin model_clear(0, 1'b1); model_clear(1, 1'b1); end
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    cmp("a.err_now", a_err, m_err[0]);     cmp("b.err_now", b_err, m_err[1]);
    cmp("a.perm", a_perm, m_perm[0]);      cmp("b.perm", b_perm, m_perm[1]);
    cmp("a.state", a_st, mstate(0));       cmp("b.state", b_st, mstate(1));
    cmp("a.mism", a_mism, m_mism[0]);      cmp("b.mism", b_mism, m_mism[1]);
    cmp("a.event", a_evt, m_evt[0]);       cmp("b.event", b_evt, m_evt[1]);
    cmp("a.trans", a_trans, m_trans[0]);   cmp("b.trans", b_trans, m_trans[1]);
    cmp("a.first", a_first, m_first[0]);   cmp("b.first", b_first, m_first[1]);
    cmp("a.fvalid", a_fv, m_fv[0]);        cmp("b.fvalid", b_fv, m_fv[1]);
`ifdef INJ_MON_PER_OUTPUT_EN
    cmp("a.y1c", a_y1c, m_y1c[0]);         cmp("b.y1c", b_y1c, m_y1c[1]);
    cmp("a.y2c", a_y2c, m_y2c[0]);         cmp("b.y2c", b_y2c, m_y2c[1]);
`endif
  end

  initial begin
    repeat (3) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    cmp("lit.rst.state", a_st, 0);  cmp("lit.rst.mism", a_mism, 0); cmp("lit.rst.event", a_evt, 0);
    cmp("lit.rst.err", a_err, 0);   cmp("lit.rst.perm", a_perm, 0); cmp("lit.rst.fv", a_fv, 0);
    cmp("lit.rst.first", a_first, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.watch", a_st, 1);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.glitch.err1", a_err, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.glitch.err0", a_err, 0);   cmp("lit.glitch.event", a_evt, 1);
    cmp("lit.glitch.trans", a_trans, 1); cmp("lit.glitch.mism", a_mism, 1);
    cmp("lit.glitch.first", a_first, 5); cmp("lit.glitch.perm", a_perm, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.th3.trans", a_trans, 1); cmp("lit.th3.perm", a_perm, 0); cmp("lit.th3.mism", a_mism, 3);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("lit.th4.pre_perm", a_perm, 0); cmp("lit.th4.pre_state", a_st, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.th4.perm", a_perm, 1);   cmp("lit.th4.state", a_st, 3);  cmp("lit.th4.event", a_evt, 2);
    cmp("lit.th4.trans", a_trans, 1); cmp("lit.th4.mism", a_mism, 7);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.sticky.state", a_st, 3); cmp("lit.sticky.mism", a_mism, 7);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.clr.state", a_st, 0);  cmp("lit.clr.mism", a_mism, 0);  cmp("lit.clr.event", a_evt, 0);
    cmp("lit.clr.fv", a_fv, 0);     cmp("lit.clr.perm", a_perm, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.clr.watch", a_st, 1);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lit.endrop.state", a_st, 0); cmp("lit.endrop.event", a_evt, 1);
    cmp("lit.endrop.trans", a_trans, 0); cmp("lit.endrop.err", a_err, 0); cmp("lit.endrop.mism", a_mism, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.reen.state", a_st, 1); cmp("lit.reen.trans", a_trans, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lit.sat.event", b_evt, 15); cmp("lit.sat.trans", b_trans, 15); cmp("lit.sat.mism", b_mism, 15);
    cmp("lit.sat.wide_event", a_evt, 20);
    repeat (3000) begin
      if ($urandom_range(99) < 25) burst = !burst;
      if ($urandom_range(999) < 5) begin
        @(negedge clk);
        #7 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end else begin
        r1 = 1'($urandom); r2 = 1'($urandom);
        drive($urandom_range(29) != 0, $urandom_range(149) == 0, burst & r1, burst & (!r1 | r2));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inj_error_monitor.md
Name: inj_error_monitor

Overview:
- Downstream checker for the fault-injection module.
- Each clock it compares the DUT outputs y1/y2 against golden copies y1_ref/y2_ref from an uninjected instance.
- It classifies each mismatch burst as transient or permanent and keeps saturating statistics that the validation bench reads out.
- It sits between the injection module outputs and the result-logging/readout logic.

Parameters:
- CNT_W, 16: width of every statistics counter and of the cycle timestamp.
- PERM_THRESH, 4: number of consecutive mismatching sampled cycles that declares a permanent fault. Legal range is 2 to 2**CNT_W-1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rstn, input, 1: asynchronous active-low reset.
- en, input, 1: monitor enable.
- clr, input, 1: synchronous clear of all statistics and flags.
- y1, input, 1: DUT output 1 from the injection module.
- y2, input, 1: DUT output 2 from the injection module.
- y1_ref, input, 1: golden output 1.
- y2_ref, input, 1: golden output 2.
- err_now, output, 1: registered mismatch of the last sampled cycle.
- perm_fault, output, 1: sticky permanent-fault flag.
- state_o, output, 2: FSM state. 0=IDLE, 1=WATCH, 2=ERROR, 3=PERM.
- mism_cnt, output, CNT_W: total sampled cycles with a mismatch.
- event_cnt, output, CNT_W: number of distinct mismatch bursts.
- trans_cnt, output, CNT_W: bursts that ended before PERM_THRESH.
- first_err_cyc, output, CNT_W: cycle timestamp of the first burst since clr/reset.
- first_valid, output, 1: first_err_cyc holds a valid value.

Behaviour:
- Reset (rstn=0, async): state IDLE; every output and counter 0; internal run_len and cyc_cnt 0. Reset mid-burst discards the burst.
- Mismatch: mis = (y1^y1_ref) | (y2^y2_ref), sampled at each rising edge.
- Sampling cycle: a cycle is a sampling cycle when en=1, clr=0, and state != IDLE.
- Priority, highest first: rstn, then clr, then en, then FSM.
- clr=1: all counters, run_len, cyc_cnt, err_now, perm_fault and first_valid go to 0; state goes to IDLE.
- en=0 (and clr=0): state goes to IDLE; err_now goes to 0; counters and perm_fault hold. An unfinished ERROR burst is dropped, with no trans_cnt increment.
- IDLE, en=1: go to WATCH. No sampling on this edge.
- In any sampling cycle: err_now <= mis; cyc_cnt increments; mism_cnt increments if mis=1.
- WATCH, mis=1: go to ERROR; run_len <= 1; event_cnt increments.
  - If first_valid=0: first_err_cyc <= cyc_cnt (value before increment) and first_valid <= 1.
- WATCH, mis=0: stay in WATCH.
- ERROR, mis=1: run_len increments.
  - If run_len+1 == PERM_THRESH: go to PERM and set perm_fault to 1 on the same edge.
- ERROR, mis=0: go to WATCH; trans_cnt increments.
- PERM: sticky until clr, en=0, or reset.
  - mism_cnt keeps counting.
  - event_cnt and trans_cnt do not change.
  - perm_fault stays 1 even when leaving PERM via en=0.
- Latency: err_now and all counters reflect the inputs sampled one edge earlier. No combinational path from inputs to outputs.
- Saturation: all counters and cyc_cnt saturate at 2**CNT_W-1 and never wrap. run_len stops at PERM_THRESH.
- Boundary: a burst of exactly PERM_THRESH-1 cycles is transient. A burst of exactly PERM_THRESH cycles is permanent.
- Back-to-back bursts separated by one clean cycle count as two events.

Optional Feature:
- Macro: INJ_MON_PER_OUTPUT_EN.
- Defined: adds two outputs, y1_mism_cnt and y2_mism_cnt (each CNT_W wide).
  - They count sampling cycles with y1^y1_ref and with y2^y2_ref respectively.
  - Same saturation, clear and reset rules as mism_cnt.
  - A cycle where both outputs mismatch increments both counters; mism_cnt increments once.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
All scenarios use PERM_THRESH=4, CNT_W=16 and a 40 ns clock unless stated.
1. Reset: hold rstn=0 for 90 ns with random y inputs -> all outputs 0, state_o=0. Release rstn with en=1 -> state_o=1 one edge later.
2. Single glitch: y1 differs from y1_ref for 1 cycle at cycle 5 after WATCH -> err_now high for exactly 1 cycle; event_cnt=1, trans_cnt=1, mism_cnt=1, first_err_cyc=5, perm_fault=0.
3. Threshold boundary: y2 mismatch for 3 cycles -> trans_cnt=1, perm_fault=0. Then a 4-cycle mismatch -> perm_fault=1 on the 4th sampling edge, state_o=3, event_cnt=2, trans_cnt=1, mism_cnt=7.
4. PERM sticky and clear: in PERM, return y2 to match and wait 10 cycles -> state_o stays 3, mism_cnt unchanged. Pulse clr -> all counters 0, first_valid=0, state_o=0, then WATCH.
5. en drop mid-burst: 2-cycle mismatch, then en=0 -> state_o=0, event_cnt=1, trans_cnt=0, err_now=0. Re-enable -> resumes in WATCH.
6. Saturation (CNT_W=4): 20 single-cycle glitches separated by clean cycles -> event_cnt=15, trans_cnt=15, mism_cnt=15, no wrap.
